// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_pkg
// Purpose  : Shared types and constants for the PC sequencer. It holds the
//            sequencer state encoding, the decoded op_class codes and the
//            default reset and interrupt vectors.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    // Sequencer states, encoded with an explicit width
    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_FETCH  = 3'd2,
        ST_DECODE = 3'd3,
        ST_UPDATE = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Decoded instruction classes
    localparam logic [1:0] c_OP_SEQ    = 2'b00;
    localparam logic [1:0] c_OP_BRANCH = 2'b01;
    localparam logic [1:0] c_OP_JUMP   = 2'b10;
    localparam logic [1:0] c_OP_HALT   = 2'b11;

    // Default vectors
    localparam logic [15:0] c_RESET_VECTOR_DEF = 16'h0000;
    localparam logic [15:0] c_IRQ_VECTOR_DEF   = 16'h0010;

endpackage : pc_seq_pkg
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_mux
// Purpose  : Purely combinational next-PC selection from the decoded class.
// Ports    : i_op_class     [1:0]  decoded instruction class
//            i_branch_taken        branch condition result
//            i_target       [15:0] branch/jump target
//            i_pc_cur       [15:0] current PC
//            o_pc_next      [15:0] selected next PC
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_mux
    import pc_seq_pkg::*;
(
    input  logic [1:0]  i_op_class,
    input  logic        i_branch_taken,
    input  logic [15:0] i_target,
    input  logic [15:0] i_pc_cur,
    output logic [15:0] o_pc_next
);

    logic [15:0] w_pc_inc;

    // 16-bit add; the carry out is dropped so FFFF wraps to 0000
    assign w_pc_inc = i_pc_cur + 16'd1;

    always_comb begin
        o_pc_next = w_pc_inc;
        case (i_op_class)
            c_OP_SEQ:    o_pc_next = w_pc_inc;
            c_OP_BRANCH: o_pc_next = i_branch_taken ? i_target : w_pc_inc;
            c_OP_JUMP:   o_pc_next = i_target;
            default:     o_pc_next = w_pc_inc; // halt: value is never written
        endcase
    end

endmodule : pc_next_mux
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program-counter sequencer FSM. It runs BOOT, IDLE, FETCH, DECODE,
//            UPDATE and HALT, and drives the PC register write and the
//            instruction fetch and load strobes.
// Macro    : PC_SEQ_IRQ_EN adds a single-level interrupt with an EPC latch.
// Ports    : clk, reset (async, active-low)
//            run, mem_ready, op_class[1:0], branch_taken, target[15:0],
//            pc_cur[15:0]                                          (in)
//            pc_next[15:0], pc_write, fetch_req, ir_load, halted  (out)
//            irq, irq_clear (in); irq_ack, epc[15:0] (out)  - IRQ build only
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = c_RESET_VECTOR_DEF,
    parameter logic [15:0] IRQ_VECTOR   = c_IRQ_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [1:0]  op_class,
    input  logic        branch_taken,
    input  logic [15:0] target,
    input  logic [15:0] pc_cur,
`ifdef PC_SEQ_IRQ_EN
    input  logic        irq,
    input  logic        irq_clear,
    output logic        irq_ack,
    output logic [15:0] epc,
`endif
    output logic [15:0] pc_next,
    output logic        pc_write,
    output logic        fetch_req,
    output logic        ir_load,
    output logic        halted
);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] w_mux_pc;
    logic [15:0] w_pc_val;
    logic        w_pc_write;
    logic        w_fetch_req;
    logic        w_ir_load;
    logic        w_halted;
`ifdef PC_SEQ_IRQ_EN
    logic        w_take_irq;
    logic        r_in_service;
    logic [15:0] r_epc;
`endif

    pc_next_mux u_pc_next_mux (
        .i_op_class     (op_class),
        .i_branch_taken (branch_taken),
        .i_target       (target),
        .i_pc_cur       (pc_cur),
        .o_pc_next      (w_mux_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_val     = 16'h0000;
        w_pc_write   = 1'b0;
        w_fetch_req  = 1'b0;
        w_ir_load    = 1'b0;
        w_halted     = 1'b0;
`ifdef PC_SEQ_IRQ_EN
        w_take_irq   = 1'b0;
`endif
        case (r_state)
            ST_BOOT: begin
                w_pc_write   = 1'b1;
                w_pc_val     = RESET_VECTOR;
                w_state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (run) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                // Waits as long as needed; run is not sampled so a started
                // instruction always runs to completion.
                w_fetch_req = 1'b1;
                if (mem_ready) begin
                    w_ir_load    = 1'b1;
                    w_state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_state_next = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (op_class == c_OP_HALT) begin
                    w_state_next = ST_HALT;
                end else begin
                    w_pc_write   = 1'b1;
                    w_pc_val     = w_mux_pc;
                    w_state_next = run ? ST_FETCH : ST_IDLE;
`ifdef PC_SEQ_IRQ_EN
                    if (irq && !r_in_service) begin
                        w_take_irq = 1'b1;
                        w_pc_val   = IRQ_VECTOR;
                    end
`endif
                end
            end
            ST_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

`ifdef PC_SEQ_IRQ_EN
    // The return address is the PC the instruction would have written had
    // the interrupt not been taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_epc        <= 16'h0000;
            r_in_service <= 1'b0;
        end else if (w_take_irq) begin
            r_epc        <= w_mux_pc;
            r_in_service <= 1'b1;
        end else if (irq_clear) begin
            r_in_service <= 1'b0;
        end
    end

    assign irq_ack = reset & w_take_irq;
    assign epc     = r_epc;
`endif

    // Reset gates the strobes combinationally so they drop without a clock
    // edge; pc_next is forced to zero whenever no write is in progress.
    assign pc_write  = reset & w_pc_write;
    assign pc_next   = pc_write ? w_pc_val : 16'h0000;
    assign fetch_req = reset & w_fetch_req;
    assign ir_load   = reset & w_ir_load;
    assign halted    = reset & w_halted;

endmodule : pc_sequencer
`default_nettype wire
